// File: rtl/zood_pkg.sv
// Shared types and widths for the Zood grading back end (tally, round tracking, result handshake).
package zood_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    UPDATE  = 2'd2,
    PRESENT = 2'd3
  } tally_state_t;

  localparam int PEG_W   = 3;  // holds a count of pegs, 0..NUM_PEGS
  localparam int CNT_W   = 3;
  localparam int ROUND_W = 4;
  localparam int SEEN_W  = 4;

endpackage

// File: rtl/grade_tally_if.sv
// Grading result bus: Zood stage inputs, new-game clear, and the valid/ack result toward the controller.
interface grade_tally_if;
  import zood_pkg::*;

  logic                clearMaster;
  logic                zoodDone;
  logic [SEEN_W-1:0]   seenOutZnarly;
  logic [SEEN_W-1:0]   seenOutZood;
  logic                gradeAck;
  logic [CNT_W-1:0]    numZnarly;
  logic [CNT_W-1:0]    numZood;
  logic [ROUND_W-1:0]  roundNum;
  logic                gradeValid;
  logic                win;
  logic                gameOver;
  logic                gradeError;
  logic                droppedGrade;

  modport master (
    output clearMaster, zoodDone, seenOutZnarly, seenOutZood, gradeAck,
    input  numZnarly, numZood, roundNum, gradeValid, win, gameOver, gradeError, droppedGrade
  );

  modport slave (
    input  clearMaster, zoodDone, seenOutZnarly, seenOutZood, gradeAck,
    output numZnarly, numZood, roundNum, gradeValid, win, gameOver, gradeError, droppedGrade
  );

endinterface

// File: rtl/grade_tally_peg_counter.sv
// Serial peg counter: captures both seen vectors and walks them one position per step.
module peg_counter
  import zood_pkg::*;
#(
  parameter int NUM_PEGS = 4
) (
  input  logic                CLOCK_50,
  input  logic                clear,
  input  logic                load,
  input  logic                step,
  input  logic [NUM_PEGS-1:0] zn_in,
  input  logic [NUM_PEGS-1:0] zd_in,
  output logic [CNT_W-1:0]    zn_cnt,
  output logic [CNT_W-1:0]    zd_cnt,
  output logic                last,
  output logic                overlap
);

  logic [NUM_PEGS-1:0] zn_r;
  logic [NUM_PEGS-1:0] zd_r;
  logic [1:0]          bit_idx;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values; the capture
  // registers are cleared too, since a clear must leave no stale vector behind for the next game.
  always_ff @(posedge CLOCK_50) begin
    if (clear) begin
      zn_r    <= '0;
      zd_r    <= '0;
      zn_cnt  <= '0;
      zd_cnt  <= '0;
      bit_idx <= '0;
    end else if (load) begin
      zn_r    <= zn_in;
      zd_r    <= zd_in;
      zn_cnt  <= '0;
      zd_cnt  <= '0;
      bit_idx <= '0;
    end else if (step) begin
      // Position under test is always bit 0; an overlapping position counts as exact only.
      zn_cnt  <= zn_cnt + CNT_W'(zn_r[0]);
      zd_cnt  <= zd_cnt + CNT_W'(zd_r[0] & ~zn_r[0]);
      zn_r    <= zn_r >> 1;
      zd_r    <= zd_r >> 1;
      bit_idx <= bit_idx + 2'd1;
    end
  end

  assign last    = (bit_idx == 2'(NUM_PEGS - 1));
  assign overlap = zn_r[0] & zd_r[0];

endmodule

// File: rtl/grade_tally.sv
// Grade tally: counts one graded guess, tracks rounds and win/game-over, and presents the result.
module grade_tally
  import zood_pkg::*;
#(
  parameter int NUM_PEGS   = 4,
  parameter int MAX_ROUNDS = 8
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  grade_tally_if.slave  bus
);

  tally_state_t        state;
  logic                clear;
  logic                load;
  logic                step;
  logic [CNT_W-1:0]    zn_cnt;
  logic [CNT_W-1:0]    zd_cnt;
  logic                last;
  logic                overlap;

  logic [CNT_W-1:0]    num_zn;
  logic [CNT_W-1:0]    num_zd;
  logic [ROUND_W-1:0]  round_num;
  logic                grade_valid;
  logic                win_r;
  logic                game_over;
  logic                grade_error;
  logic                dropped;

  logic [ROUND_W:0]    round_inc;
  logic                win_next;

  assign clear     = reset | bus.clearMaster;
  assign load      = (state == IDLE) & bus.zoodDone & ~game_over;
  assign step      = (state == COUNT);
  assign round_inc = {1'b0, round_num} + 1'b1;
  assign win_next  = win_r | (zn_cnt == PEG_W'(NUM_PEGS));

  peg_counter #(.NUM_PEGS(NUM_PEGS)) u_peg_counter (
    .CLOCK_50 (CLOCK_50),
    .clear    (clear),
    .load     (load),
    .step     (step),
    .zn_in    (bus.seenOutZnarly),
    .zd_in    (bus.seenOutZood),
    .zn_cnt   (zn_cnt),
    .zd_cnt   (zd_cnt),
    .last     (last),
    .overlap  (overlap)
  );

  always_ff @(posedge CLOCK_50) begin
    if (clear) begin
      state       <= IDLE;
      num_zn      <= '0;
      num_zd      <= '0;
      round_num   <= '0;
      grade_valid <= 1'b0;
      win_r       <= 1'b0;
      game_over   <= 1'b0;
      grade_error <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      // A pulse while a guess is in flight is lost; the in-flight capture is left alone.
      if (bus.zoodDone && state != IDLE) dropped <= 1'b1;

      case (state)
        IDLE: begin
          if (load) state <= COUNT;
        end
        COUNT: begin
          if (overlap) grade_error <= 1'b1;
          if (last)    state       <= UPDATE;
        end
        UPDATE: begin
          num_zn <= zn_cnt;
          num_zd <= zd_cnt;
          if (round_num != ROUND_W'(MAX_ROUNDS)) round_num <= round_inc[ROUND_W-1:0];
          win_r       <= win_next;
          game_over   <= game_over | win_next | (round_inc == (ROUND_W+1)'(MAX_ROUNDS));
          grade_valid <= 1'b1;
          state       <= PRESENT;
        end
        PRESENT: begin
          if (bus.gradeAck) begin
            grade_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.numZnarly    = num_zn;
  assign bus.numZood      = num_zd;
  assign bus.roundNum     = round_num;
  assign bus.gradeValid   = grade_valid;
  assign bus.win          = win_r;
  assign bus.gameOver     = game_over;
  assign bus.gradeError   = grade_error;
  assign bus.droppedGrade = dropped;

endmodule

// File: tb/tb_grade_tally.sv
// Self-checking bench for grade_tally: directed scenarios plus randomized games against a scoring model.
module tb_grade_tally;
  import zood_pkg::*;

  localparam int MAX_R = 8;

  logic CLOCK_50 = 1'b0;
  logic reset;

  grade_tally_if bus ();

  grade_tally #(.NUM_PEGS(4), .MAX_ROUNDS(MAX_R)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: scores computed straight from the scoring rules.
  int m_zn, m_zd, m_round;
  bit m_win, m_over, m_err, m_drop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic model_clear();
    m_zn = 0; m_zd = 0; m_round = 0;
    m_win = 0; m_over = 0; m_err = 0; m_drop = 0;
  endtask

  task automatic model_score(input logic [3:0] zn, input logic [3:0] zd);
    m_zn    = $countones(zn);
    m_zd    = $countones(zd & ~zn);
    m_err   = m_err | (|(zn & zd));
    m_round = (m_round < MAX_R) ? m_round + 1 : MAX_R;
    m_win   = m_win | (m_zn == 4);
    m_over  = m_over | m_win | (m_round == MAX_R);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_numZnarly"},    bus.numZnarly,    m_zn);
    check({tag, "_numZood"},      bus.numZood,      m_zd);
    check({tag, "_roundNum"},     bus.roundNum,     m_round);
    check({tag, "_win"},          bus.win,          m_win);
    check({tag, "_gameOver"},     bus.gameOver,     m_over);
    check({tag, "_gradeError"},   bus.gradeError,   m_err);
    check({tag, "_droppedGrade"}, bus.droppedGrade, m_drop);
  endtask

  task automatic clear_game();
    bus.clearMaster = 1'b1;
    tick();
    bus.clearMaster = 1'b0;
    model_clear();
    check("clear_valid", bus.gradeValid, 0);
    check_all("clear");
  endtask

  // One guess. ev_kind: 0 none, 1 extra zoodDone at T+ev_at, 2 clearMaster at T+ev_at,
  // 3 reset while presenting. pdrop pulses zoodDone while the result is presented.
  task automatic guess(input logic [3:0] zn, input logic [3:0] zd, input int ack_delay,
                       input int ev_kind, input int ev_at, input bit pdrop);
    int n;
    bit got;
    bus.seenOutZnarly = zn;
    bus.seenOutZood   = zd;
    bus.zoodDone      = 1'b1;
    if (m_over) begin
      tick();
      bus.zoodDone = 1'b0;
      repeat (8) tick();
      check("over_valid", bus.gradeValid, 0);
      check_all("over_ignored");
      return;
    end
    n = 0;
    got = 0;
    while (n < 20 && !got) begin
      tick();
      n++;
      if (n == 1) bus.zoodDone = 1'b0;
      if (n == ev_at && ev_kind == 1) begin
        bus.seenOutZnarly = 4'($urandom);
        bus.seenOutZood   = 4'($urandom);
        bus.zoodDone      = 1'b1;
        m_drop            = 1;
      end
      if (n == ev_at && ev_kind == 2) bus.clearMaster = 1'b1;
      if (n == ev_at + 1) begin
        bus.zoodDone    = 1'b0;
        bus.clearMaster = 1'b0;
      end
      if (bus.gradeValid) got = 1;
    end
    if (ev_kind == 2) begin
      check("midclear_no_valid", got, 0);
      model_clear();
      check_all("midclear");
      return;
    end
    check("valid_seen", got, 1);
    check("latency", n, 6);
    model_score(zn, zd);
    check_all("result");
    if (ev_kind == 3) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_clear();
      check("rst_valid", bus.gradeValid, 0);
      check_all("rst_present");
      return;
    end
    for (int i = 0; i < ack_delay; i++) begin
      if (pdrop && i == 0) begin
        bus.seenOutZnarly = 4'($urandom);
        bus.seenOutZood   = 4'($urandom);
        bus.zoodDone      = 1'b1;
      end
      tick();
      bus.zoodDone = 1'b0;
      if (pdrop && i == 0) m_drop = 1;
      check("hold_valid", bus.gradeValid, 1);
    end
    check_all("held");
    bus.gradeAck = 1'b1;
    tick();
    bus.gradeAck = 1'b0;
    check("ack_valid", bus.gradeValid, 0);
    check_all("acked");
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] zn, zd;
    reset             = 1'b1;
    bus.clearMaster   = 1'b0;
    bus.zoodDone      = 1'b0;
    bus.seenOutZnarly = '0;
    bus.seenOutZood   = '0;
    bus.gradeAck      = 1'b0;
    model_clear();
    repeat (3) tick();
    reset = 1'b0;
    check("reset_valid", bus.gradeValid, 0);
    check_all("reset");

    // Exact win, then a further guess is ignored.
    guess(4'b1111, 4'b0000, 1, 0, 0, 0);
    check("t1_win", bus.win, 1);
    check("t1_round", bus.roundNum, 1);
    guess(4'b0001, 4'b0010, 0, 0, 0, 0);
    check("t1_round_after", bus.roundNum, 1);
    clear_game();

    // Mixed, long hold; stray ack in IDLE first.
    bus.gradeAck = 1'b1;
    repeat (3) tick();
    bus.gradeAck = 1'b0;
    check("idle_ack_valid", bus.gradeValid, 0);
    guess(4'b0101, 4'b1010, 5, 0, 0, 0);
    check("t2_zn", bus.numZnarly, 2);
    check("t2_zd", bus.numZood, 2);

    // Overlap.
    guess(4'b0011, 4'b0110, 0, 0, 0, 0);
    check("t3_zd", bus.numZood, 1);
    check("t3_err", bus.gradeError, 1);
    clear_game();

    // Exhaustion.
    for (int g = 0; g < MAX_R; g++) guess(4'b0000, 4'b0000, 0, 0, 0, 0);
    check("t4_round", bus.roundNum, 8);
    check("t4_over", bus.gameOver, 1);
    guess(4'b1111, 4'b0000, 0, 0, 0, 0);
    clear_game();

    // Busy drop at T+3.
    guess(4'b1001, 4'b0100, 1, 1, 3, 0);
    check("t5_drop", bus.droppedGrade, 1);
    clear_game();

    // Clear mid-count, clear coincident with zoodDone, reset while presenting.
    guess(4'b0110, 4'b1000, 0, 2, 2, 0);
    bus.seenOutZnarly = 4'b1111;
    bus.zoodDone      = 1'b1;
    bus.clearMaster   = 1'b1;
    tick();
    bus.zoodDone    = 1'b0;
    bus.clearMaster = 1'b0;
    repeat (8) tick();
    check("coclear_valid", bus.gradeValid, 0);
    check_all("coclear");
    guess(4'b0010, 4'b0101, 0, 3, 0, 0);

    // Randomized games.
    for (int g = 0; g < 80; g++) begin
      if (m_over) begin
        if ($urandom_range(0, 1) == 1) guess(4'($urandom), 4'($urandom), 0, 0, 0, 0);
        clear_game();
      end
      zn = 4'($urandom);
      if ($urandom_range(0, 7) == 0) zn = 4'b1111;
      zd = 4'($urandom);
      if ($urandom_range(0, 2) != 0) zd = zd & ~zn;
      case ($urandom_range(0, 9))
        0:       guess(zn, zd, $urandom_range(1, 3), 1, $urandom_range(2, 5), 0);
        1:       guess(zn, zd, 0, 2, $urandom_range(2, 5), 0);
        2:       guess(zn, zd, $urandom_range(1, 3), 0, 0, 1);
        default: guess(zn, zd, $urandom_range(0, 3), 0, 0, 0);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
